// File: rtl/interrupt_pkg.sv
// Shared constants and state encoding for the interrupt scheduler and its watchdog.
package interrupt_pkg;
  localparam logic [6:0]  INT_ID          = 7'd72;
  localparam logic [11:0] USER_OFFSET     = 12'd3;
  localparam logic [11:0] WATCHDOG_OFFSET = 12'd0;

  localparam int SRC_USER = 0;
  localparam int SRC_WD   = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVICE = 2'd1,
    HOLDOFF = 2'd2
  } state_e;
endpackage

// File: rtl/watchdog_timer.sv
// Reloadable down-counter; o_expire pulses for the cycle in which the counter sits at 1.
module watchdog_timer #(
  parameter int                  WD_WIDTH   = 32,
  parameter logic [WD_WIDTH-1:0] WD_DEFAULT = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_load,
  input  logic [WD_WIDTH-1:0] i_load_value,
  input  logic                i_kick,
  output logic                o_expire,
  output logic [WD_WIDTH-1:0] o_count
);
  logic [WD_WIDTH-1:0] r_reload;
  logic [WD_WIDTH-1:0] r_count;
  logic                w_armed;

  assign w_armed  = (r_reload != '0);
  // Load and kick both restart the period, so they suppress an expiry in the same cycle.
  assign o_expire = w_armed & ~i_load & ~i_kick & (r_count == WD_WIDTH'(1));
  assign o_count  = r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_reload <= WD_DEFAULT;
      r_count  <= WD_DEFAULT;
    end else if (i_load) begin
      r_reload <= i_load_value;
      r_count  <= i_load_value;
    end else if (i_kick) begin
      r_count  <= r_reload;
    end else if (w_armed) begin
      if (r_count <= WD_WIDTH'(1)) r_count <= r_reload;
      else                         r_count <= r_count - WD_WIDTH'(1);
    end
  end
endmodule

// File: rtl/interrupt_scheduler.sv
// Latches user/watchdog interrupt events and injects at most one per instruction boundary,
// then waits for the ISR return plus one plain instruction before injecting again.
module interrupt_scheduler
  import interrupt_pkg::*;
#(
  parameter int                  WD_WIDTH   = 32,
  parameter logic [WD_WIDTH-1:0] WD_DEFAULT = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                user_request,
  input  logic                fetch_boundary,
  input  logic                irq_enable,
  input  logic                return_from_interrupt,
  input  logic                wd_load,
  input  logic [WD_WIDTH-1:0] wd_load_value,
  input  logic                wd_kick,
  output logic                user_interruption,
  output logic                watchdog_interruption,
  output logic                in_service,
  output logic [1:0]          pending,
  output logic [WD_WIDTH-1:0] wd_count
);
  logic       r_sync1, r_sync2, r_prev;
  logic [1:0] r_pending;
  state_e     r_state;

  logic       w_user_evt, w_wd_evt, w_inject, w_sel_wd;
  logic [1:0] w_set, w_clr;

  watchdog_timer #(
    .WD_WIDTH   (WD_WIDTH),
    .WD_DEFAULT (WD_DEFAULT)
  ) u_wd (
    .clock        (clock),
    .reset        (reset),
    .i_load       (wd_load),
    .i_load_value (wd_load_value),
    .i_kick       (wd_kick),
    .o_expire     (w_wd_evt),
    .o_count      (wd_count)
  );

  // Button line is asynchronous: two flops before edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= user_request;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_user_evt = r_sync2 & ~r_prev;

  assign w_inject              = (r_state == IDLE) & irq_enable & fetch_boundary & (|r_pending);
  assign w_sel_wd              = r_pending[SRC_WD];
  assign watchdog_interruption = w_inject & w_sel_wd;
  assign user_interruption     = w_inject & ~w_sel_wd;

  always_comb begin
    w_set           = '0;
    w_clr           = '0;
    w_set[SRC_USER] = w_user_evt;
    w_set[SRC_WD]   = w_wd_evt;
    w_clr[SRC_USER] = user_interruption;
    w_clr[SRC_WD]   = watchdog_interruption;
  end

  // A fresh event in the clearing cycle must survive, so set is OR-ed after the clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_pending <= '0;
    else        r_pending <= (r_pending & ~w_clr) | w_set;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_inject)              r_state <= SERVICE;
        SERVICE: if (return_from_interrupt) r_state <= HOLDOFF;
        HOLDOFF: if (fetch_boundary)        r_state <= IDLE;
        default:                            r_state <= IDLE;
      endcase
    end
  end

  assign in_service = (r_state == SERVICE);
  assign pending    = r_pending;
endmodule

// File: tb/tb_interrupt_scheduler.sv
// Scenario bench for interrupt_scheduler: expected injections queued at stimulus time, popped by a monitor.
module tb_interrupt_scheduler;
  import interrupt_pkg::*;

  localparam int WDW = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           user_request = 1'b0;
  logic           fetch_boundary = 1'b0;
  logic           irq_enable = 1'b0;
  logic           return_from_interrupt = 1'b0;
  logic           wd_load = 1'b0;
  logic [WDW-1:0] wd_load_value = '0;
  logic           wd_kick = 1'b0;
  logic           user_interruption, watchdog_interruption, in_service;
  logic [1:0]     pending;
  logic [WDW-1:0] wd_count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  interrupt_scheduler #(.WD_WIDTH(WDW), .WD_DEFAULT('0)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .user_request          (user_request),
    .fetch_boundary        (fetch_boundary),
    .irq_enable            (irq_enable),
    .return_from_interrupt (return_from_interrupt),
    .wd_load               (wd_load),
    .wd_load_value         (wd_load_value),
    .wd_kick               (wd_kick),
    .user_interruption     (user_interruption),
    .watchdog_interruption (watchdog_interruption),
    .in_service            (in_service),
    .pending               (pending),
    .wd_count              (wd_count)
  );

  always #5 clock = ~clock;

  // Every injection pulse must match the head of the expectation queue; one pop per high cycle.
  always @(negedge clock) begin : mon
    int e, got;
    #2;
    if (user_interruption || watchdog_interruption) begin
      checks++;
      if (user_interruption && watchdog_interruption) begin
        errors++; $display("FAIL both_high user=1 wd=1 required one-hot");
      end else if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_inject user=%0b wd=%0b required none", user_interruption, watchdog_interruption);
      end else begin
        e   = exp_q.pop_front();
        got = watchdog_interruption ? SRC_WD : SRC_USER;
        if (got != e) begin
          errors++; $display("FAIL inject_source got %0d required %0d", got, e);
        end
      end
    end
  end

  task automatic step();
    @(negedge clock);
  endtask

  task automatic finish_isr();
    step(); return_from_interrupt = 1'b1; fetch_boundary = 1'b0;
    step(); return_from_interrupt = 1'b0; fetch_boundary = 1'b1;
    step(); fetch_boundary = 1'b0;
    #2;
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL finish_isr_state got %0d required %0d", dut.r_state, IDLE); end
  endtask

  task automatic test_reset();
    repeat (2) step();
    reset = 1'b1;
    step(); wd_load = 1'b1; wd_load_value = 7;
    step(); wd_load = 1'b0;
    repeat (3) step();
    #2;
    checks++; if (wd_count !== 4) begin errors++; $display("FAIL pre_reset_count got %0d required 4", wd_count); end
    #1 reset = 1'b0;
    #1;
    checks++; if (wd_count !== '0) begin errors++; $display("FAIL reset_count got %0d required 0", wd_count); end
    checks++; if (pending !== 2'b00) begin errors++; $display("FAIL reset_pending got %b required 00", pending); end
    checks++; if ({user_interruption, watchdog_interruption, in_service} !== 3'b000) begin
      errors++; $display("FAIL reset_outputs got %b required 000", {user_interruption, watchdog_interruption, in_service}); end
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL reset_state got %0d required 0", dut.r_state); end
    step(); reset = 1'b1;
    repeat (3) step();
    #2;
    checks++; if (wd_count !== '0) begin errors++; $display("FAIL disarmed_count got %0d required 0", wd_count); end
  endtask

  task automatic test_user();
    step(); irq_enable = 1'b1; fetch_boundary = 1'b1; user_request = 1'b1;
    step(); #2;
    checks++; if (pending !== 2'b00) begin errors++; $display("FAIL user_sync1 pending got %b required 00", pending); end
    step(); #2;
    checks++; if (pending !== 2'b00) begin errors++; $display("FAIL user_sync2 pending got %b required 00", pending); end
    step(); exp_q.push_back(SRC_USER); #2;
    checks++; if (pending !== 2'b01) begin errors++; $display("FAIL user_pending got %b required 01", pending); end
    checks++; if (user_interruption !== 1'b1) begin errors++; $display("FAIL user_inject got %b required 1", user_interruption); end
    step(); #2;
    checks++; if ({in_service, pending} !== 3'b100) begin errors++; $display("FAIL user_service got %b required 100", {in_service, pending}); end
    repeat (2) step(); #2;
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL user_fb_ignored got %b required 1", in_service); end
    step(); return_from_interrupt = 1'b1;
    step(); return_from_interrupt = 1'b0; fetch_boundary = 1'b0; #2;
    checks++; if (dut.r_state !== HOLDOFF) begin errors++; $display("FAIL user_holdoff got %0d required %0d", dut.r_state, HOLDOFF); end
    step(); fetch_boundary = 1'b1;
    step(); fetch_boundary = 1'b0; #2;
    checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL user_idle got %0d required %0d", dut.r_state, IDLE); end
    user_request = 1'b0;
    repeat (4) step(); #2;
    checks++; if (pending !== 2'b00) begin errors++; $display("FAIL user_level_once got %b required 00", pending); end
    irq_enable = 1'b0;
  endtask

  task automatic test_watchdog();
    step(); wd_load = 1'b1; wd_load_value = 5;
    step(); wd_load = 1'b0;
    repeat (4) step(); #2;
    checks++; if ({pending, wd_count} !== {2'b00, 32'd1}) begin errors++; $display("FAIL wd_before got p=%b c=%0d required p=00 c=1", pending, wd_count); end
    step(); exp_q.push_back(SRC_WD); irq_enable = 1'b1; fetch_boundary = 1'b1; #2;
    checks++; if ({pending, wd_count} !== {2'b10, 32'd5}) begin errors++; $display("FAIL wd_first got p=%b c=%0d required p=10 c=5", pending, wd_count); end
    step(); fetch_boundary = 1'b0; return_from_interrupt = 1'b1; irq_enable = 1'b0; #2;
    checks++; if ({in_service, pending} !== 3'b100) begin errors++; $display("FAIL wd_service got %b required 100", {in_service, pending}); end
    step(); return_from_interrupt = 1'b0; fetch_boundary = 1'b1;
    step(); fetch_boundary = 1'b0;
    step(); #2;
    checks++; if ({pending, wd_count} !== {2'b00, 32'd1}) begin errors++; $display("FAIL wd_mid got p=%b c=%0d required p=00 c=1", pending, wd_count); end
    step(); #2;
    checks++; if ({pending, wd_count} !== {2'b10, 32'd5}) begin errors++; $display("FAIL wd_second got p=%b c=%0d required p=10 c=5", pending, wd_count); end
    step(); exp_q.push_back(SRC_WD); irq_enable = 1'b1; fetch_boundary = 1'b1;
    step(); fetch_boundary = 1'b0; return_from_interrupt = 1'b1; irq_enable = 1'b0;
    step(); return_from_interrupt = 1'b0; fetch_boundary = 1'b1;
    step(); fetch_boundary = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wd_kick = 1'b1; step();
      wd_kick = 1'b0; step(); step();
    end
    #2;
    checks++; if ({pending, wd_count} !== {2'b00, 32'd3}) begin errors++; $display("FAIL wd_kicked got p=%b c=%0d required p=00 c=3", pending, wd_count); end
    wd_load = 1'b1; wd_load_value = '0;
    step(); wd_load = 1'b0;
    repeat (8) step(); #2;
    checks++; if ({pending, wd_count} !== {2'b00, 32'd0}) begin errors++; $display("FAIL wd_disarm got p=%b c=%0d required p=00 c=0", pending, wd_count); end
  endtask

  task automatic test_simultaneous();
    step(); user_request = 1'b1; wd_load = 1'b1; wd_load_value = 4;
    step(); wd_load = 1'b0;
    repeat (5) step(); #2;
    checks++; if (pending !== 2'b11) begin errors++; $display("FAIL sim_pending got %b required 11", pending); end
    wd_load = 1'b1; wd_load_value = '0;
    step(); wd_load = 1'b0; user_request = 1'b0;
    step(); exp_q.push_back(SRC_WD); irq_enable = 1'b1; fetch_boundary = 1'b1; #2;
    checks++; if ({watchdog_interruption, user_interruption} !== 2'b10) begin
      errors++; $display("FAIL sim_wd_first got %b required 10", {watchdog_interruption, user_interruption}); end
    step(); #2;
    checks++; if ({in_service, pending} !== 3'b101) begin errors++; $display("FAIL sim_service got %b required 101", {in_service, pending}); end
    step(); return_from_interrupt = 1'b1;
    step(); return_from_interrupt = 1'b0; #2;
    checks++; if ({dut.r_state == HOLDOFF, user_interruption} !== 2'b10) begin
      errors++; $display("FAIL sim_holdoff got st=%0d u=%b required st=2 u=0", dut.r_state, user_interruption); end
    step(); exp_q.push_back(SRC_USER); #2;
    checks++; if (user_interruption !== 1'b1) begin errors++; $display("FAIL sim_user_second got %b required 1", user_interruption); end
    step(); fetch_boundary = 1'b0; irq_enable = 1'b0; #2;
    checks++; if ({in_service, pending} !== 3'b100) begin errors++; $display("FAIL sim_user_service got %b required 100", {in_service, pending}); end
    finish_isr();
  endtask

  task automatic test_coalesce();
    step();
    for (int i = 0; i < 3; i++) begin
      user_request = 1'b1; repeat (3) step();
      user_request = 1'b0; repeat (3) step();
    end
    #2;
    checks++; if (pending !== 2'b01) begin errors++; $display("FAIL coal_pending got %b required 01", pending); end
    step(); exp_q.push_back(SRC_USER); irq_enable = 1'b1; fetch_boundary = 1'b1;
    step(); fetch_boundary = 1'b0; #2;
    checks++; if ({in_service, pending} !== 3'b100) begin errors++; $display("FAIL coal_service got %b required 100", {in_service, pending}); end
    finish_isr();
    step(); fetch_boundary = 1'b1;
    repeat (5) step();
    fetch_boundary = 1'b0; irq_enable = 1'b0; #2;
    checks++; if (pending !== 2'b00) begin errors++; $display("FAIL coal_once got %b required 00", pending); end
  endtask

  task automatic test_service_event();
    step(); user_request = 1'b1; irq_enable = 1'b1; fetch_boundary = 1'b1;
    step(); step();
    step(); exp_q.push_back(SRC_USER); user_request = 1'b0;
    step(); user_request = 1'b1; #2;
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL svc_enter got %b required 1", in_service); end
    step(); step(); user_request = 1'b0;
    step(); #2;
    checks++; if ({in_service, pending} !== 3'b101) begin errors++; $display("FAIL svc_latched got %b required 101", {in_service, pending}); end
    step(); return_from_interrupt = 1'b1;
    step(); return_from_interrupt = 1'b0; #2;
    checks++; if ({dut.r_state == HOLDOFF, user_interruption, pending} !== 4'b1001) begin
      errors++; $display("FAIL svc_holdoff got st=%0d u=%b p=%b required st=2 u=0 p=01", dut.r_state, user_interruption, pending); end
    step(); exp_q.push_back(SRC_USER); #2;
    checks++; if (user_interruption !== 1'b1) begin errors++; $display("FAIL svc_inject got %b required 1", user_interruption); end
    step(); fetch_boundary = 1'b0; irq_enable = 1'b0; #2;
    checks++; if ({in_service, pending} !== 3'b100) begin errors++; $display("FAIL svc_second got %b required 100", {in_service, pending}); end
    finish_isr();
  endtask

  task automatic test_reset_service();
    step(); user_request = 1'b1; irq_enable = 1'b1; fetch_boundary = 1'b1;
    step(); step();
    step(); exp_q.push_back(SRC_USER); user_request = 1'b0;
    step(); fetch_boundary = 1'b0; user_request = 1'b1;
    step(); step();
    step(); #2;
    checks++; if ({in_service, pending} !== 3'b101) begin errors++; $display("FAIL rs_before got %b required 101", {in_service, pending}); end
    #1 reset = 1'b0;
    #1;
    checks++; if ({in_service, pending} !== 3'b000) begin errors++; $display("FAIL rs_async got %b required 000", {in_service, pending}); end
    step(); reset = 1'b1; user_request = 1'b0; irq_enable = 1'b0;
    repeat (3) step(); #2;
    checks++; if ({dut.r_state == IDLE, pending} !== 3'b100) begin
      errors++; $display("FAIL rs_after got st=%0d p=%b required st=0 p=00", dut.r_state, pending); end
  endtask

  initial begin
    test_reset();
    test_user();
    test_watchdog();
    test_simultaneous();
    test_coalesce();
    test_service_event();
    test_reset_service();
    repeat (2) step();
    #3;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL missing_injections got %0d left required 0", exp_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
